uart_fifo_ctl: RTL and testbench
================================

# uart_fifo_ctl

Memory-mapped UART controller with parametrised TX and RX FIFOs, an autonomous TX drain state machine, sticky error flags and a level interrupt. It sits between the SoC peripheral bus and the UART TX/RX serialisers, and replaces single-byte register access with buffered access. Software can queue up to TX_DEPTH bytes and collect up to RX_DEPTH bytes without polling per byte.

## Interface
- TX_DEPTH, 8: TX FIFO entries; power of 2, 2..128
- RX_DEPTH, 8: RX FIFO entries; power of 2, 2..128
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  32  byte address; only [3:0] decoded
- mem_wdata  in  32  write data
- mem_we  in  1  write strobe, one cycle per access
- mem_re  in  1  read strobe, one cycle per access; never asserted together with mem_we
- mem_rdata  out  32  registered read data
- uart_tx_en  out  1  one-cycle launch pulse to the transmitter
- uart_tx_data  out  8  byte to transmit; held stable from launch until the next launch
- uart_tx_busy  in  1  transmitter busy; rises the cycle after uart_tx_en and stays high until the frame ends
- uart_rx_en  out  1  receiver enable (CTRL bit1)
- uart_rx_break  in  1  break level from the receiver
- uart_rx_valid  in  1  one-cycle strobe; uart_rx_data is valid in that cycle
- uart_rx_data  in  8  received byte
- irq  out  1  registered level interrupt

## Operation
Register map (mem_addr[3:0]). Unlisted offsets read 0 and ignore writes.
- 0x0 TXDATA (W)
  - Write pushes mem_wdata[7:0] into the TX FIFO.
  - If the FIFO is full, the byte is dropped and TXOVF is set.
  - Reads return 0.
- 0x4 STATUS (R, W1C)
  - bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full
  - bit4 RXOVR (sticky), bit5 TXOVF (sticky)
  - bit6 rx_break (uart_rx_break registered once)
  - bit7 tx_active: FSM not in IDLE, or uart_tx_busy high
  - [15:8] tx_count, [23:16] rx_count, [31:24] zero
  - Writing 1 to bit4 or bit5 clears that flag. If a set event occurs in the same cycle as the clear, the set wins.
- 0x8 RXDATA (R)
  - Read returns {24'b0, head} and pops the RX FIFO.
  - If the FIFO is empty, the read returns 0 and does not pop.
  - Writes are ignored.
- 0xC CTRL (R/W)
  - bit0 tx_enable, bit1 rx_en, bit2 irq_rx_en, bit3 irq_tx_en, bit4 irq_err_en
  - bit5 tx_flush and bit6 rx_flush are self-clearing and always read 0.
  - Flush zeroes that FIFO's pointers and count in the write cycle.

RX path
- Push on uart_rx_valid when rx_en=1; bytes arriving with rx_en=0 are discarded.
- Push while full without a pop in the same cycle: the new byte is dropped, RXOVR is set, and FIFO contents are unchanged.
- Push and pop in the same cycle: both take effect and the count is unchanged. This applies even when the FIFO is full.
- rx_flush in the same cycle as uart_rx_valid: flush wins and the byte is dropped.

TX drain FSM
- IDLE → LAUNCH when tx_enable=1, the TX FIFO is not empty, uart_tx_busy=0 and no tx_flush is written that cycle. On this transition the head is popped into uart_tx_data.
- LAUNCH: uart_tx_en=1 for exactly this cycle. → WAIT_ACK.
- WAIT_ACK: → WAIT_DONE when uart_tx_busy=1.
- WAIT_DONE: → IDLE when uart_tx_busy=0.
- Clearing tx_enable stops new launches only; a byte already in flight completes.
- tx_flush never aborts a byte already popped.

Interrupt
- irq is registered: (irq_rx_en & !rx_empty) | (irq_tx_en & tx_empty & FSM==IDLE) | (irq_err_en & (RXOVR|TXOVF)).

Arithmetic
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Counts are log2(DEPTH)+1 bits, zero-extended into their 8-bit STATUS fields.

## Timing
- Reset: mem_rdata=0, uart_tx_en=0, uart_tx_data=0, uart_rx_en=0, irq=0. CTRL, flags and FIFO counts are 0; FSM is in IDLE.
- Reset asserted mid-frame returns to IDLE immediately and discards both FIFOs.
- Reads: mem_rdata updates on the edge after mem_re and holds until the next read.
- RX pop and status effects take place on the same edge as the read.
- Write effects (push, flush, W1C, CTRL) are visible on the edge after mem_we.
- TXDATA write into an empty FIFO with tx_enable=1 and transmitter idle: count=1 after edge N+1, IDLE→LAUNCH at edge N+2, uart_tx_en high in cycle N+2.
- Minimum spacing between consecutive launches is 3 cycles plus the transmitter's busy duration.
- irq lags its source conditions by one cycle.

## Test plan
- TX burst: CTRL=0x1, write 0x41, 0x42, 0x43. Model busy as 10 cycles per byte. Expect three uart_tx_en pulses carrying 0x41, 0x42, 0x43 in order, each launch only after busy falls, then tx_empty=1 and tx_active=0.
- TX overflow: tx_enable=0, write TX_DEPTH+1 bytes. Expect STATUS tx_full=1, TXOVF=1, tx_count=TX_DEPTH. Write STATUS=0x20 → TXOVF=0.
- RX fill and overrun: rx_en=1, inject RX_DEPTH+1 bytes 0x00..0x08 (depth 8). Expect RXOVR=1 and eight reads returning 0x00..0x07. A ninth read returns 0 and rx_empty stays 1.
- RX full with simultaneous push and pop: FIFO full, RXDATA read in the same cycle as uart_rx_valid=0x5A. Expect no RXOVR, count stays 8, and 0x5A is read last.
- IRQ: CTRL=0x06 with RX FIFO empty → irq=0. Inject 0x33 → irq=1 one cycle after the push. Read RXDATA → irq=0 one cycle later.
- Flush and reset: queue 4 TX bytes with tx_enable=0, write CTRL=0x21. Expect tx_count=0 and no uart_tx_en pulse. Assert rst_n low mid-frame → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_fifo_ctl.sv
// Memory-mapped UART controller: buffered TX/RX FIFOs behind a small register map,
// an autonomous TX drain state machine, sticky error flags and a level interrupt.
module uart_fifo_ctl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] mem_rdata,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    input  logic        uart_tx_busy,
    output logic        uart_rx_en,
    input  logic        uart_rx_break,
    input  logic        uart_rx_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        irq
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_CW = RX_AW + 1;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_RXDATA = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_WAIT_ACK,
        TX_WAIT_DONE
    } tx_state_t;

    tx_state_t tx_state;
    tx_state_t tx_state_next;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [3:0] addr;
    logic       wr_txdata;
    logic       wr_status;
    logic       wr_ctrl;
    logic       rd_rxdata;
    logic       tx_flush;
    logic       rx_flush;

    assign addr      = mem_addr[3:0];
    assign wr_txdata = mem_we && (addr == ADDR_TXDATA);
    assign wr_status = mem_we && (addr == ADDR_STATUS);
    assign wr_ctrl   = mem_we && (addr == ADDR_CTRL);
    assign rd_rxdata = mem_re && (addr == ADDR_RXDATA);
    assign tx_flush  = wr_ctrl && mem_wdata[5];
    assign rx_flush  = wr_ctrl && mem_wdata[6];

    logic unused_bits;
    assign unused_bits = ^{mem_addr[31:4], mem_wdata[31:8]};

    // ------------------------------------------------------------------
    // Control register: tx_enable, rx_en, irq_rx_en, irq_tx_en, irq_err_en
    // ------------------------------------------------------------------
    logic [4:0] ctrl;
    logic       tx_enable;
    logic       rx_en;
    logic       irq_rx_en;
    logic       irq_tx_en;
    logic       irq_err_en;

    assign tx_enable  = ctrl[0];
    assign rx_en      = ctrl[1];
    assign irq_rx_en  = ctrl[2];
    assign irq_tx_en  = ctrl[3];
    assign irq_err_en = ctrl[4];
    assign uart_rx_en = rx_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= mem_wdata[4:0];
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr;
    logic [TX_AW-1:0] tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_push;
    logic             tx_pop;

    assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_push  = wr_txdata && !tx_full;
    // A flush written this cycle suppresses the launch so no stale byte escapes.
    assign tx_pop   = (tx_state == TX_IDLE) && tx_enable && !tx_empty &&
                      !uart_tx_busy && !tx_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            if (tx_push && !tx_pop) begin
                tx_count <= tx_count + 1'b1;
            end else if (tx_pop && !tx_push) begin
                tx_count <= tx_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_tx_data <= '0;
        end else if (tx_pop) begin
            uart_tx_data <= tx_mem[tx_rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // TX drain FSM. Handshake: uart_tx_en is a one-cycle launch; the
    // transmitter acknowledges by raising uart_tx_busy the next cycle and
    // drops it at end of frame. No launch is made while uart_tx_busy is high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_next;
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        uart_tx_en    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (tx_pop) begin
                    tx_state_next = TX_LAUNCH;
                end
            end
            TX_LAUNCH: begin
                uart_tx_en    = 1'b1;
                tx_state_next = TX_WAIT_ACK;
            end
            TX_WAIT_ACK: begin
                if (uart_tx_busy) begin
                    tx_state_next = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr;
    logic [RX_AW-1:0] rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic             rx_full;
    logic             rx_empty;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_write;
    logic             rx_ovr_set;

    assign rx_full    = (rx_count == RX_CW'(RX_DEPTH));
    assign rx_empty   = (rx_count == '0);
    assign rx_push    = uart_rx_valid && rx_en && !rx_flush;
    assign rx_pop     = rd_rxdata && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign rx_write   = rx_push && (!rx_full || rx_pop);
    assign rx_ovr_set = rx_push && rx_full && !rx_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_write) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            if (rx_write && !rx_pop) begin
                rx_count <= rx_count + 1'b1;
            end else if (rx_pop && !rx_write) begin
                rx_count <= rx_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_write) begin
            rx_mem[rx_wr_ptr] <= uart_rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags and break sampling
    // ------------------------------------------------------------------
    logic rxovr;
    logic txovf;
    logic rx_break_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxovr      <= 1'b0;
            txovf      <= 1'b0;
            rx_break_q <= 1'b0;
        end else begin
            rx_break_q <= uart_rx_break;
            if (rx_ovr_set) begin
                rxovr <= 1'b1;
            end else if (wr_status && mem_wdata[4]) begin
                rxovr <= 1'b0;
            end
            if (wr_txdata && tx_full) begin
                txovf <= 1'b1;
            end else if (wr_status && mem_wdata[5]) begin
                txovf <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path and interrupt
    // ------------------------------------------------------------------
    logic        tx_active;
    logic [7:0]  tx_count_b;
    logic [7:0]  rx_count_b;
    logic [31:0] status_word;
    logic [31:0] rd_value;

    assign tx_active   = (tx_state != TX_IDLE) || uart_tx_busy;
    assign tx_count_b  = 8'(tx_count);
    assign rx_count_b  = 8'(rx_count);
    assign status_word = {8'h00, rx_count_b, tx_count_b, tx_active, rx_break_q,
                          txovf, rxovr, rx_full, rx_empty, tx_empty, tx_full};

    always_comb begin
        rd_value = '0;
        case (addr)
            ADDR_STATUS: rd_value = status_word;
            ADDR_RXDATA: begin
                if (!rx_empty) begin
                    rd_value = {24'h0, rx_mem[rx_rd_ptr]};
                end
            end
            ADDR_CTRL:   rd_value = {27'h0, ctrl};
            default:     rd_value = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            if (mem_re) begin
                mem_rdata <= rd_value;
            end
            irq <= (irq_rx_en && !rx_empty) ||
                   (irq_tx_en && tx_empty && (tx_state == TX_IDLE)) ||
                   (irq_err_en && (rxovr || txovf));
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Self-checking bench for uart_fifo_ctl: directed steps plus randomized traffic,
// checked against queue-based models of the FIFOs, flags and launch order.
module tb_uart_fifo_ctl;

    localparam int TXD = 8;
    localparam int RXD = 8;
    localparam logic [3:0] A_TX   = 4'h0;
    localparam logic [3:0] A_STAT = 4'h4;
    localparam logic [3:0] A_RX   = 4'h8;
    localparam logic [3:0] A_CTRL = 4'hC;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy;
    logic        uart_rx_en;
    logic        uart_rx_break;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] m_txq[$];
    logic [7:0] m_rxq[$];
    bit         m_txovf;
    bit         m_rxovr;
    bit         m_brk;
    bit         m_rxen;
    int         busy_fixed;

    uart_fifo_ctl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_rx_en   (uart_rx_en),
        .uart_rx_break(uart_rx_break),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_data (uart_rx_data),
        .irq          (irq)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Transmitter model: records every launch and answers with a busy window
    initial begin
        int blen;
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx_en === 1'b1) begin
                got_q.push_back(uart_tx_data);
                check("launch_while_busy", 32'(uart_tx_busy), 32'h0);
                blen = (busy_fixed != 0) ? busy_fixed : int'($urandom_range(1, 12));
                @(posedge clk);
                #1 uart_tx_busy = 1'b1;
                repeat (blen) @(posedge clk);
                #1 uart_tx_busy = 1'b0;
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step(input logic we, input logic re, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd);
        logic [27:0] hi;
        hi = 28'($urandom());
        mem_we        = we;
        mem_re        = re;
        mem_addr      = {hi, addr};
        mem_wdata     = wdata;
        uart_rx_valid = rxv;
        uart_rx_data  = rxd;
        @(posedge clk);
        #1;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        uart_rx_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        step(1'b1, 1'b0, addr, data, 1'b0, 8'h00);
    endtask

    task automatic bus_read(input logic [3:0] addr, output logic [31:0] rd);
        step(1'b0, 1'b1, addr, 32'h0, 1'b0, 8'h00);
        rd = mem_rdata;
    endtask

    task automatic rx_inject(input logic [7:0] b);
        step(1'b0, 1'b0, A_TX, 32'h0, 1'b1, b);
    endtask

    function automatic logic [31:0] status_exp(input bit tx_act);
        return {8'h00, 8'(m_rxq.size()), 8'(m_txq.size()), tx_act, m_brk, m_txovf, m_rxovr,
                m_rxq.size() == RXD, m_rxq.size() == 0, m_txq.size() == 0, m_txq.size() == TXD};
    endfunction

    task automatic check_status(input string tag, input bit tx_act);
        logic [31:0] rd;
        bus_read(A_STAT, rd);
        check(tag, rd, status_exp(tx_act));
    endtask

    // Scoreboard: wait for all expected launches, then compare in order
    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while (got_q.size() < exp_q.size() && cyc < 3000) begin
            idle(1);
            cyc++;
        end
        idle(2);
        while (uart_tx_busy && cyc < 3000) begin
            idle(1);
            cyc++;
        end
        idle(3);
        check({tag, "_timeout"}, 32'(cyc >= 3000), 32'h0);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check({tag, "_byte"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_rd;
        logic [7:0]  b;
        int          n;
        int          r;
        int          size_before;
        int          cyc;
        bit          do_inj;
        bit          do_rd;
        bit          popped;

        rst_n         = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        uart_rx_break = 1'b0;
        uart_rx_valid = 1'b0;
        uart_rx_data  = '0;
        busy_fixed    = 10;
        m_txovf       = 1'b0;
        m_rxovr       = 1'b0;
        m_brk         = 1'b0;
        m_rxen        = 1'b0;

        // Reset values
        idle(3);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_tx_en", 32'(uart_tx_en), 32'h0);
        check("rst_tx_data", 32'(uart_tx_data), 32'h0);
        check("rst_rx_en", 32'(uart_rx_en), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        idle(1);
        check_status("rst_status", 1'b0);
        bus_read(A_CTRL, rd);
        check("rst_ctrl", rd, 32'h0);

        // TX burst with first-launch latency
        bus_write(A_CTRL, 32'h1);
        exp_q.push_back(8'h41);
        bus_write(A_TX, 32'h41);
        check("tx_lat_idle", 32'(uart_tx_en), 32'h0);
        exp_q.push_back(8'h42);
        bus_write(A_TX, 32'h42);
        check("tx_lat_launch", 32'(uart_tx_en), 32'h1);
        check("tx_lat_data", 32'(uart_tx_data), 32'h41);
        exp_q.push_back(8'h43);
        bus_write(A_TX, 32'h43);
        wait_drain("burst");
        check_status("burst_status", 1'b0);

        // Random TX bytes with random gaps and busy lengths
        busy_fixed = 0;
        n = $urandom_range(3, 7);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            bus_write(A_TX, {24'h0, b});
            idle($urandom_range(0, 15));
        end
        wait_drain("rand_tx");
        check_status("rand_tx_status", 1'b0);

        // TX overflow, error interrupt, W1C, then drain across pointer wrap
        bus_write(A_CTRL, 32'h0);
        for (int i = 0; i < TXD + 1; i++) begin
            b = 8'($urandom_range(0, 255));
            if (m_txq.size() < TXD) m_txq.push_back(b);
            else m_txovf = 1'b1;
            bus_write(A_TX, {24'h0, b});
        end
        check_status("txovf_status", 1'b0);
        bus_write(A_CTRL, 32'h10);
        idle(1);
        check("irq_err", 32'(irq), 32'h1);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STAT, 32'h20);
        m_txovf = 1'b0;
        check_status("txovf_clear", 1'b0);
        bus_write(A_CTRL, 32'h1);
        exp_q = m_txq;
        m_txq.delete();
        wait_drain("ovf_drain");
        check_status("ovf_drain_status", 1'b0);

        // RX fill and overrun
        bus_write(A_CTRL, 32'h2);
        m_rxen = 1'b1;
        check("rx_en_out", 32'(uart_rx_en), 32'h1);
        for (int i = 0; i <= RXD; i++) begin
            if (m_rxq.size() < RXD) m_rxq.push_back(8'(i));
            else m_rxovr = 1'b1;
            rx_inject(8'(i));
        end
        check_status("rx_full_status", 1'b0);
        for (int i = 0; i < RXD; i++) begin
            bus_read(A_RX, rd);
            check("rx_fill_read", rd, {24'h0, m_rxq.pop_front()});
        end
        bus_read(A_RX, rd);
        check("rx_empty_read", rd, 32'h0);
        check_status("rx_empty_status", 1'b0);
        bus_write(A_STAT, 32'h10);
        m_rxovr = 1'b0;

        // Break level
        uart_rx_break = 1'b1;
        m_brk = 1'b1;
        idle(1);
        check_status("break_status", 1'b0);
        uart_rx_break = 1'b0;
        m_brk = 1'b0;
        idle(1);

        // RX full with simultaneous push and pop
        for (int i = 0; i < RXD; i++) begin
            b = 8'($urandom_range(0, 255));
            m_rxq.push_back(b);
            rx_inject(b);
        end
        exp_rd = {24'h0, m_rxq.pop_front()};
        m_rxq.push_back(8'h5A);
        step(1'b0, 1'b1, A_RX, 32'h0, 1'b1, 8'h5A);
        check("rx_simul_read", mem_rdata, exp_rd);
        check_status("rx_simul_status", 1'b0);
        for (int i = 0; i < RXD; i++) begin
            bus_read(A_RX, rd);
            check("rx_simul_drain", rd, {24'h0, m_rxq.pop_front()});
        end

        // Randomized RX traffic against the queue model
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r == 9) begin
                m_rxen = 1'($urandom_range(0, 1));
                bus_write(A_CTRL, {30'h0, m_rxen, 1'b0});
            end else begin
                do_inj = (r <= 4) || (r == 8);
                do_rd = (r >= 5);
                b = 8'($urandom_range(0, 255));
                exp_rd = 32'h0;
                popped = 1'b0;
                size_before = m_rxq.size();
                if (do_rd && size_before > 0) begin
                    exp_rd = {24'h0, m_rxq.pop_front()};
                    popped = 1'b1;
                end
                if (do_inj && m_rxen) begin
                    if (size_before < RXD || popped) m_rxq.push_back(b);
                    else m_rxovr = 1'b1;
                end
                step(1'b0, do_rd, A_RX, 32'h0, do_inj, b);
                if (do_rd) check("rx_rand_read", mem_rdata, exp_rd);
            end
        end
        check_status("rx_rand_status", 1'b0);
        while (m_rxq.size() > 0) begin
            bus_read(A_RX, rd);
            check("rx_rand_drain", rd, {24'h0, m_rxq.pop_front()});
        end
        bus_write(A_STAT, 32'h10);
        m_rxovr = 1'b0;

        // Interrupt timing
        bus_write(A_CTRL, 32'h6);
        m_rxen = 1'b1;
        idle(1);
        check("irq_idle", 32'(irq), 32'h0);
        rx_inject(8'h33);
        m_rxq.push_back(8'h33);
        check("irq_push_edge", 32'(irq), 32'h0);
        idle(1);
        check("irq_rx", 32'(irq), 32'h1);
        bus_read(A_RX, rd);
        check("irq_rx_read", rd, {24'h0, m_rxq.pop_front()});
        check("irq_pop_edge", 32'(irq), 32'h1);
        idle(1);
        check("irq_rx_clear", 32'(irq), 32'h0);
        bus_write(A_CTRL, 32'h8);
        idle(1);
        check("irq_tx", 32'(irq), 32'h1);
        bus_write(A_CTRL, 32'h0);
        m_rxen = 1'b0;
        idle(1);
        check("irq_off", 32'(irq), 32'h0);

        // TX flush together with tx_enable: nothing may launch
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            m_txq.push_back(b);
            bus_write(A_TX, {24'h0, b});
        end
        check_status("pre_flush_status", 1'b0);
        bus_write(A_CTRL, 32'h21);
        m_txq.delete();
        idle(20);
        check("flush_no_launch", 32'(got_q.size()), 32'h0);
        check_status("tx_flush_status", 1'b0);
        bus_read(A_CTRL, rd);
        check("flush_ctrl_read", rd, 32'h1);

        // RX flush in the same cycle as an arriving byte
        bus_write(A_CTRL, 32'h3);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom_range(0, 255));
            m_rxq.push_back(b);
            rx_inject(b);
        end
        step(1'b1, 1'b0, A_CTRL, 32'h43, 1'b1, 8'h77);
        m_rxq.delete();
        check_status("rx_flush_status", 1'b0);

        // Reset asserted mid-frame
        busy_fixed = 10;
        bus_write(A_CTRL, 32'hF);
        rx_inject(8'h11);
        m_rxq.push_back(8'h11);
        exp_q.push_back(8'hA5);
        bus_write(A_TX, 32'hA5);
        cyc = 0;
        while (!uart_tx_busy && cyc < 50) begin
            idle(1);
            cyc++;
        end
        check("mid_frame_timeout", 32'(cyc >= 50), 32'h0);
        check_status("mid_frame_status", 1'b1);
        check("mid_frame_irq", 32'(irq), 32'h1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_rdata", mem_rdata, 32'h0);
        check("async_rst_tx_en", 32'(uart_tx_en), 32'h0);
        check("async_rst_tx_data", 32'(uart_tx_data), 32'h0);
        check("async_rst_rx_en", 32'(uart_rx_en), 32'h0);
        check("async_rst_irq", 32'(irq), 32'h0);
        m_rxq.delete();
        m_txq.delete();
        m_txovf = 1'b0;
        m_rxovr = 1'b0;
        m_brk = 1'b0;
        idle(2);
        rst_n = 1'b1;
        wait_drain("reset_frame");
        check_status("post_reset_status", 1'b0);
        bus_read(A_CTRL, rd);
        check("post_reset_ctrl", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
